// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths and opcode encodings used by the ALU
// and by every block that feeds it.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SEL_W = 3;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_ADDU = 3'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 3'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_SUBU = 3'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 3'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 3'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 3'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 3'd7;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Operation-in and result-out valid/ready handshakes of the ALU issue stage.
// master = producer/consumer side, slave = the issue stage.
interface alu_issue_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SEL_W = ALU_SEL_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SEL_W-1:0] in_sel;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [SEL_W-1:0] res_sel;

  modport master (
    output in_valid, in_a, in_b, in_sel, res_ready,
    input  in_ready, res_valid, res_data, res_sel
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, res_ready,
    output in_ready, res_valid, res_data, res_sel
  );

endinterface

// File: rtl/alu_issue_fifo.sv
// Generic DEPTH-entry FIFO with occupancy-based full/empty. Storage is written
// only at the tail, so the head word never changes on a push.
module alu_issue_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign occupancy = count;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rdata     = mem[rd_ptr];

  // NOTE: storage has no reset; count gates every read, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU: buffers operations in a FIFO,
// presents the head to the ALU and registers the result into a handshaked slot.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_issue_stage_if.slave       bus,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [SEL_W-1:0]       alu_sel,
  input  logic [WIDTH-1:0]       alu_result,
  output logic [$clog2(DEPTH):0] occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SEL_W-1:0] sel;
  } op_t;

  op_t  push_op;
  op_t  head_op;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic slot_free;

  assign push_op      = {bus.in_a, bus.in_b, bus.in_sel};
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && bus.in_ready;
  assign slot_free    = !bus.res_valid || bus.res_ready;
  assign pop          = !empty && slot_free;

  alu_issue_fifo #(
    .DATA_W ($bits(op_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (push_op),
    .rdata     (head_op),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!empty) begin
      alu_a   = head_op.a;
      alu_b   = head_op.b;
      alu_sel = head_op.sel;
    end
  end

  // A pop refills the slot in the same edge that the consumer empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_sel   <= '0;
    end else if (pop) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= alu_result;
      bus.res_sel   <= alu_sel;
    end else if (bus.res_ready && bus.res_valid) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
  } op_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic [2:0]  occupancy;

  int tests  = 0;
  int failed = 0;

  // Reference model: queue of buffered ops plus the result slot.
  op_t         mq[$];
  logic        m_slot_v    = 1'b0;
  logic [31:0] m_slot_data = '0;
  logic [2:0]  m_slot_sel  = '0;

  alu_issue_stage_if #(.WIDTH(32), .SEL_W(3)) bus ();

  alu_issue_stage #(.WIDTH(32), .DEPTH(DEPTH), .SEL_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] sel);
    case (sel)
      ALU_ADD, ALU_ADDU: return a + b;
      ALU_SUB, ALU_SUBU: return a - b;
      ALU_AND:           return a & b;
      ALU_OR:            return a | b;
      ALU_SRA:           return $unsigned($signed(a) >>> b[4:0]);
      default:           return a >> b[4:0];
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("in_ready", bus.in_ready, mq.size() != DEPTH);
    check("occupancy", occupancy, mq.size());
    check("res_valid", bus.res_valid, m_slot_v);
    if (m_slot_v) begin
      check("res_data", bus.res_data, m_slot_data);
      check("res_sel", bus.res_sel, m_slot_sel);
    end
    check("alu_a", alu_a, (mq.size() != 0) ? mq[0].a : 32'd0);
    check("alu_sel", alu_sel, (mq.size() != 0) ? mq[0].sel : 3'd0);
  endtask

  // Drive one cycle of inputs, advance one clock, update the model, compare.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel, input logic rr);
    logic m_push;
    logic m_pop;
    op_t  op;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sel    = sel;
    bus.res_ready = rr;
    m_push = v && (mq.size() != DEPTH);
    m_pop  = (mq.size() != 0) && (!m_slot_v || rr);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_slot_v    = 1'b0;
      m_slot_data = '0;
      m_slot_sel  = '0;
    end else begin
      if (m_pop) begin
        op          = mq.pop_front();
        m_slot_data = alu_fn(op.a, op.b, op.sel);
        m_slot_sel  = op.sel;
        m_slot_v    = 1'b1;
      end else if (rr && m_slot_v) begin
        m_slot_v = 1'b0;
      end
      if (m_push) mq.push_back('{a: a, b: b, sel: sel});
    end
    compare_model();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) cycle(1'b1, 32'hdead, 32'hbeef, ALU_ADD, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] got[$];
    int          bubbles;
    logic        seen;

    vecs[0] = '{a: 32'd5,          b: 32'd3,          sel: ALU_SUB,  exp: 32'd2};
    vecs[1] = '{a: 32'd5,          b: 32'd3,          sel: ALU_ADD,  exp: 32'd8};
    vecs[2] = '{a: 32'hffff_ffff,  b: 32'd1,          sel: ALU_ADDU, exp: 32'd0};
    vecs[3] = '{a: 32'd3,          b: 32'd5,          sel: ALU_SUBU, exp: 32'hffff_fffe};
    vecs[4] = '{a: 32'h0000_f0f0,  b: 32'h0000_ff00,  sel: ALU_AND,  exp: 32'h0000_f000};
    vecs[5] = '{a: 32'h0000_f0f0,  b: 32'h0000_0f0f,  sel: ALU_OR,   exp: 32'h0000_ffff};
    vecs[6] = '{a: 32'h8000_0000,  b: 32'd4,          sel: ALU_SRA,  exp: 32'hf800_0000};
    vecs[7] = '{a: 32'h8000_0000,  b: 32'd4,          sel: ALU_SRL,  exp: 32'h0800_0000};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = '0;
    bus.res_ready = 1'b0;

    // Reset held two cycles with in_valid high: nothing may be accepted.
    do_reset(2);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_occupancy", occupancy, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_sel", bus.res_sel, 0);

    // Single ops: accepted at edge N, result valid after edge N+1.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].sel, 1'b1);
      check("vec_no_early_valid", bus.res_valid, 1'b0);
      check("vec_head_a", alu_a, vecs[i].a);
      cycle(1'b0, '0, '0, ALU_ADD, 1'b1);
      check("vec_valid", bus.res_valid, 1'b1);
      check("vec_data", bus.res_data, vecs[i].exp);
      check("vec_sel", bus.res_sel, vecs[i].sel);
      cycle(1'b0, '0, '0, ALU_ADD, 1'b1);
    end

    // Back-pressure: 5 accepted ops fill slot + FIFO, then drain in order.
    do_reset(1);
    for (int k = 0; k < 5; k++) cycle(1'b1, 32'(10 + k), 32'd2, ALU_ADD, 1'b0);
    check("bp_in_ready", bus.in_ready, 1'b0);
    check("bp_occupancy", occupancy, 4);
    check("bp_slot", bus.res_data, 12);
    cycle(1'b1, 32'd99, 32'd99, ALU_ADD, 1'b0);
    check("bp_no_push_full", occupancy, 4);
    check("bp_slot_hold", bus.res_data, 12);
    got.delete();
    got.push_back(bus.res_data);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, '0, '0, ALU_ADD, 1'b1);
      if (bus.res_valid) got.push_back(bus.res_data);
    end
    check("bp_drain_count", got.size(), 5);
    for (int k = 0; k < got.size(); k++) check("bp_drain_order", got[k], 32'(12 + k));
    check("bp_drained", bus.res_valid, 1'b0);

    // Streaming: 16 back-to-back ADDs, no bubbles after the first result.
    got.delete();
    bubbles = 0;
    seen    = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (i < 16) cycle(1'b1, 32'(i), 32'd1, ALU_ADD, 1'b1);
      else        cycle(1'b0, '0, '0, ALU_ADD, 1'b1);
      if (bus.res_valid) begin
        seen = 1'b1;
        got.push_back(bus.res_data);
      end else if (seen && got.size() < 16) begin
        bubbles++;
      end
    end
    check("stream_count", got.size(), 16);
    check("stream_bubbles", bubbles, 0);
    for (int i = 0; i < got.size(); i++) check("stream_data", got[i], 32'(i + 1));

    // Wrap: hold occupancy at 2 with push and pop every cycle.
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'(200 + k), 32'd0, ALU_OR, 1'b0);
    check("wrap_fill", occupancy, 2);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 32'(300 + k), 32'd7, ALU_SUB, 1'b1);
      check("wrap_occupancy", occupancy, 2);
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, ALU_ADD, 1'b1);

    // Reset mid-stream with occupancy 3 and a held result.
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'(100 + k), 32'd0, ALU_OR, 1'b0);
    check("mid_occupancy", occupancy, 3);
    check("mid_res_valid", bus.res_valid, 1'b1);
    rst = 1'b1;
    cycle(1'b1, 32'd7, 32'd7, ALU_ADD, 1'b1);
    rst = 1'b0;
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_valid", bus.res_valid, 1'b0);
    check("mid_rst_data", bus.res_data, 0);
    check("mid_rst_ready", bus.in_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, '0, ALU_ADD, 1'b1);
      check("mid_no_stale", bus.res_valid, 1'b0);
    end

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, ALU_ADD, 1'b1);
    check("final_empty", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
